// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and the stages around it.
//   FIR_OUT_W   : width of the raw filter result
//   SAMPLE_W    : width of a finished output sample
//   fir_out_t   : signed raw filter result
//   sample_t    : signed output sample
//   round_sat() : round-half-up, arithmetic right shift, then saturate.
//                 It returns the limited value and a saturation indicator.
package fir_pkg;

  localparam int FIR_OUT_W = 32;
  localparam int SAMPLE_W  = 16;

  // Internal arithmetic width. It is wide enough that adding the rounding
  // term to any input up to 62 bits cannot overflow.
  localparam int CALC_W = 64;

  typedef logic signed [FIR_OUT_W-1:0] fir_out_t;
  typedef logic signed [SAMPLE_W-1:0]  sample_t;
  typedef logic signed [CALC_W-1:0]    calc_t;

  typedef struct packed {
    logic  sat;
    calc_t value;
  } round_sat_t;

  // Callers pass constant shift and outW values, so the variable shifts
  // below reduce to wiring.
  function automatic round_sat_t round_sat(input calc_t value,
                                           input int    shift,
                                           input int    outW);
    calc_t      rounded;
    calc_t      maxV;
    calc_t      minV;
    round_sat_t res;
    if (shift > 0) begin
      rounded = (value + (calc_t'(1) <<< (shift - 1))) >>> shift;
    end else begin
      rounded = value;
    end
    maxV      = (calc_t'(1) <<< (outW - 1)) - calc_t'(1);
    minV      = -(calc_t'(1) <<< (outW - 1));
    res.sat   = 1'b0;
    res.value = rounded;
    if (rounded > maxV) begin
      res.value = maxV;
      res.sat   = 1'b1;
    end else if (rounded < minV) begin
      res.value = minV;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and count-based flags.
//   clk, rst : clock and asynchronous active-low reset
//   push_i   : write wdata_i. It is ignored when the FIFO is full, unless
//              a pop happens in the same cycle.
//   pop_i    : remove the head entry. It is ignored when the FIFO is empty.
//   wdata_i  : data to write
//   rdata_o  : head entry. When the FIFO is empty it holds the last value
//              popped, which is 0 after reset.
//   full_o   : FIFO is full
//   empty_o  : FIFO is empty
// DEPTH must be a power of two (at least 2) so that the pointers wrap on
// their own.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] lastPop_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = empty_o ? lastPop_q : mem[rdPtr_q];

  // The storage array needs no reset: an entry is only read after it has
  // been written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      lastPop_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q   <= rdPtr_q + 1'b1;
        lastPop_q <= mem[rdPtr_q];
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_decim.sv
// Output stage for the 17-tap FIR. It discards the warm-up samples,
// decimates, rounds and saturates each kept sample, and buffers the
// results for a valid/ready consumer.
//   clk, rst   : clock and asynchronous active-low reset
//   din        : signed filter result (IN_WIDTH bits)
//   din_en     : input sample strobe
//   dout       : signed output sample (the FIFO head)
//   dout_valid : the FIFO holds at least one sample
//   dout_ready : the consumer takes dout this cycle
//   clr_flags  : synchronous clear of the sticky flags. A flag set in the
//                same cycle takes priority over the clear.
//   sat_flag   : sticky; a kept sample saturated
//   ovr_flag   : sticky; a kept sample was dropped because the FIFO was full
module fir_out_decim
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_OUT_W,
  parameter int OUT_WIDTH  = SAMPLE_W,
  parameter int SHIFT      = 16,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  din,
  input  logic                        din_en,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  input  logic                        clr_flags,
  output logic                        sat_flag,
  output logic                        ovr_flag
);

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [WU_W-1:0]             warmCnt_q, warmCnt_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic                        stageVld_q, stageVld_d;
  logic signed [OUT_WIDTH-1:0] stageData_q, stageData_d;
  logic                        satFlag_q, satFlag_d;
  logic                        ovrFlag_q, ovrFlag_d;

  logic                        warmDone, keep;
  logic                        fifoFull, fifoEmpty;
  logic                        push, pop, drop;
  round_sat_t                  rs;
  logic                        unusedBits;

  assign rs         = round_sat(calc_t'(din), SHIFT, OUT_WIDTH);
  assign unusedBits = ^rs.value[CALC_W-1:OUT_WIDTH];
  assign warmDone   = (warmCnt_q == WU_W'(WARMUP));

  // Warm-up counting, decimation phase and stage-register capture. The
  // phase counter only starts once warm-up is over, so the first sample
  // after warm-up always has phase 0 and is always kept.
  always_comb begin
    warmCnt_d   = warmCnt_q;
    phase_d     = phase_q;
    keep        = 1'b0;
    stageVld_d  = 1'b0;
    stageData_d = stageData_q;
    if (din_en) begin
      if (!warmDone) begin
        warmCnt_d = warmCnt_q + 1'b1;
      end else begin
        keep    = (phase_q == '0);
        phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
      end
    end
    if (keep) begin
      stageVld_d  = 1'b1;
      stageData_d = rs.value[OUT_WIDTH-1:0];
    end
  end

  // FIFO handshake and sticky flags. A full FIFO can still accept the
  // staged sample when the consumer pops in the same cycle.
  always_comb begin
    pop       = !fifoEmpty && dout_ready;
    drop      = stageVld_q && fifoFull && !pop;
    push      = stageVld_q && !drop;
    satFlag_d = (satFlag_q && !clr_flags) || (keep && rs.sat);
    ovrFlag_d = (ovrFlag_q && !clr_flags) || drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warmCnt_q   <= '0;
      phase_q     <= '0;
      stageVld_q  <= 1'b0;
      stageData_q <= '0;
      satFlag_q   <= 1'b0;
      ovrFlag_q   <= 1'b0;
    end else begin
      warmCnt_q   <= warmCnt_d;
      phase_q     <= phase_d;
      stageVld_q  <= stageVld_d;
      stageData_q <= stageData_d;
      satFlag_q   <= satFlag_d;
      ovrFlag_q   <= ovrFlag_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (stageData_q),
    .rdata_o (dout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign dout_valid = !fifoEmpty;
  assign sat_flag   = satFlag_q;
  assign ovr_flag   = ovrFlag_q;

endmodule
